// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_adder_pkg;

    // Operand width used when the parent does not override WIDTH
    localparam int DEFAULT_WIDTH = 8;

    // Control FSM encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder used as the serial datapath slice.
// Latency: combinational.
// Backpressure: none.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic carry
);

    assign s     = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per cycle, LSB first, through one full adder.
// Latency: start accepted at E0 -> sum/cout/done updated at E(WIDTH); done pulses for one cycle.
// Backpressure: none; start is ignored while busy, so callers must wait for busy low.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Partial result: holds the WIDTH-1 bits produced so far, newest at the top
    logic [WIDTH-2:0] res;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] res_nxt;

    full_adder u_full_adder (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c     (carry_q),
        .s     (fa_s),
        .carry (fa_c)
    );

    // On the final bit this concatenation is the complete, correctly ordered result
    assign res_nxt = {fa_s, res};

    // Control FSM plus serial datapath; busy/done are registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res     <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    res     <= res_nxt[WIDTH-1:1];
                    carry_q <= fa_c;
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        sum   <= res_nxt;
                        cout  <= fa_c;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin an addition; sampled on the rising edge of clk.
REQ-005 Port: a  input  WIDTH  augend; captured when start is accepted.
REQ-006 Port: b  input  WIDTH  addend; captured when start is accepted.
REQ-007 Port: cin  input  1  carry-in; captured when start is accepted.
REQ-008 Port: busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 Port: done  output  1  one-cycle pulse marking a new valid result.
REQ-010 Port: sum  output  WIDTH  registered result of the last completed operation.
REQ-011 Port: cout  output  1  registered carry-out of the last completed operation.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 IDLE with start=1 at an edge SHALL do all of the following: load a and b into shift registers, load cin into the carry flop, clear the bit counter, and go to SHIFT.
REQ-014 IDLE with start=0 SHALL remain in IDLE.
REQ-015 Each SHIFT edge SHALL process one bit, LSB first, through the full_adder sub-module:
  - the sum bit shifts into the result register;
  - the carry flop takes the full_adder carry;
  - the operand registers shift right by one;
  - the counter increments.
REQ-016 The SHIFT edge that processes bit WIDTH-1 SHALL do all of the following: write the assembled result to sum, write the final carry to cout, and go to DONE.
REQ-017 Latency: if start is accepted at edge E0, bits 0..WIDTH-1 SHALL be processed at edges E1..E(WIDTH), and done SHALL be high from E(WIDTH) to E(WIDTH+1).
REQ-018 DONE SHALL last exactly one cycle and SHALL go unconditionally to IDLE.
REQ-019 start SHALL be ignored in SHIFT and DONE; the in-flight operation and its operands SHALL be unaffected.
REQ-020 With start held high continuously, a new operation SHALL begin every WIDTH+2 cycles.
REQ-021 sum and cout SHALL hold their values between completions and SHALL change only on the REQ-016 edge.
REQ-022 Result = (a + b + cin) mod 2^WIDTH; cout = bit WIDTH of the full sum.
REQ-023 Changes to a, b and cin after acceptance SHALL NOT affect the result.
REQ-024 busy SHALL be high in SHIFT and DONE and low in IDLE.
REQ-025 done SHALL be high only in DONE.

Reset
REQ-026 While rst=1, independent of clk, the block SHALL hold all of the following: state=IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry flop=0, operand registers=0.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no done pulse and no update to sum or cout.
REQ-028 The first edge after rst deasserts SHALL accept start normally.

Structure
REQ-029 Package serial_adder_pkg SHALL contain the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-030 The bit counter SHALL be $clog2(WIDTH) bits wide.
REQ-031 The block SHALL contain exactly one instance of the existing full_adder sub-module (inputs a, b, c; outputs s, carry) as the single-bit datapath.
REQ-032 No multi-bit adder SHALL be inferred.

Verification (WIDTH=8)
REQ-033 Basic add: a=8'h3C, b=8'h0F, cin=0, start at E0 -> done high at E8..E9, sum=8'h4B, cout=0, busy high E0..E9.
REQ-034 Overflow: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-035 Start while busy: start at E0 with a=8'h01, b=8'h01; at E3 pulse start with a=8'h80, b=8'h80 -> one done only, sum=8'h02, cout=0.
REQ-036 Reset mid-operation: assert rst between E4 and E5 -> all outputs 0 immediately, no done; after release, a=8'h10, b=8'h20 -> sum=8'h30.
REQ-037 Back-to-back: hold start=1 -> done pulses exactly 10 cycles apart; sum=8'h00 throughout until first done; operands changed mid-operation do not alter that operation's result.
